// File: rtl/cache_pkg.sv
// Shared types, geometry and address helpers for the direct-mapped cache.
// Latency: none (package only).
// Backpressure: n/a.
package cache_pkg;

  localparam int WORD            = 32;
  localparam int ADDRESSL        = 32;
  localparam int OFFSET_BITS     = 2;
  localparam int INDEX_BITS      = 10;
  localparam int TAG_BITS        = ADDRESSL - INDEX_BITS - OFFSET_BITS;
  localparam int COUNT_W         = 32;
  localparam int NUM_SETS        = 1 << INDEX_BITS;
  localparam int WORDS_PER_BLOCK = 1 << OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE,
    RESPOND
  } state_t;

  // Processor request as captured on acceptance.
  typedef struct packed {
    logic                we;
    logic [ADDRESSL-1:0] address;
    logic [WORD-1:0]     wdata;
  } req_t;

  function automatic logic [OFFSET_BITS-1:0] getOffset(input logic [ADDRESSL-1:0] a);
    return a[OFFSET_BITS-1:0];
  endfunction

  function automatic logic [INDEX_BITS-1:0] getIndex(input logic [ADDRESSL-1:0] a);
    return a[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [TAG_BITS-1:0] getTag(input logic [ADDRESSL-1:0] a);
    return a[ADDRESSL-1 -: TAG_BITS];
  endfunction

  // Word address of word 'cnt' within the block holding address 'a'.
  function automatic logic [ADDRESSL-1:0] blockWordAddress(input logic [ADDRESSL-1:0]    a,
                                                           input logic [OFFSET_BITS-1:0] cnt);
    return {getTag(a), getIndex(a), cnt};
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] c);
    return (c == '1) ? c : c + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/cache_storage.sv
// Valid/tag/data arrays of the cache: one combinational read port, one word write port.
// Latency: read is combinational; writes and line validation land on the rising edge.
// Backpressure: none, every write strobe is accepted.
module cache_storage
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_BITS-1:0]  rdIndex,
  input  logic [OFFSET_BITS-1:0] rdOffset,
  output logic                   rdValid,
  output logic [TAG_BITS-1:0]    rdTag,
  output logic [WORD-1:0]        rdData,
  input  logic                   wrEn,
  input  logic [INDEX_BITS-1:0]  wrIndex,
  input  logic [OFFSET_BITS-1:0] wrOffset,
  input  logic [WORD-1:0]        wrData,
  input  logic                   validateEn,
  input  logic [TAG_BITS-1:0]    validateTag
);

  logic [NUM_SETS-1:0] validBits;
  logic [TAG_BITS-1:0] tagMem  [NUM_SETS];
  logic [WORD-1:0]     dataMem [NUM_SETS*WORDS_PER_BLOCK];

  assign rdValid = validBits[rdIndex];
  assign rdTag   = tagMem[rdIndex];
  assign rdData  = dataMem[{rdIndex, rdOffset}];

  // Valid bits: cleared by reset so no stale or half-filled line survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validBits <= '0;
    end else if (validateEn) begin
      validBits[wrIndex] <= 1'b1;
    end
  end

  // Tag and data arrays: plain storage, only meaningful under a set valid bit.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      dataMem[{wrIndex, wrOffset}] <= wrData;
    end
    if (validateEn) begin
      tagMem[wrIndex] <= validateTag;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, read-allocate, write-through cache between CPU data port and word memory.
// Latency: read hit 1 cycle after accept, read miss 6 (4 refill beats), write 2.
// Backpressure: one request in flight; cpu_req is only sampled in IDLE, memory is zero-wait.
module cache_controller
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDRESSL-1:0] cpu_address,
  input  logic [WORD-1:0]     cpu_wdata,
  output logic [WORD-1:0]     cpu_rdata,
  output logic                cpu_ready,
  output logic [ADDRESSL-1:0] mem_address,
  output logic [WORD-1:0]     mem_write_data,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [WORD-1:0]     mem_read_data,
  output logic [COUNT_W-1:0]  hit_count,
  output logic [COUNT_W-1:0]  miss_count
);

  state_t                 state, nextState;
  req_t                   req;
  logic [OFFSET_BITS-1:0] refillCnt;
  logic [ADDRESSL-1:0]    memAddrHold;
  logic [WORD-1:0]        memWdataHold;

  logic                   rdValid;
  logic [TAG_BITS-1:0]    rdTag;
  logic [WORD-1:0]        rdData;
  logic                   hit;

  logic                   stWrEn;
  logic [OFFSET_BITS-1:0] stWrOffset;
  logic [WORD-1:0]        stWrData;
  logic                   stValidate;

  assign hit = rdValid && (rdTag == getTag(req.address));

  cache_storage uStorage (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdIndex     (getIndex(req.address)),
    .rdOffset    (getOffset(req.address)),
    .rdValid     (rdValid),
    .rdTag       (rdTag),
    .rdData      (rdData),
    .wrEn        (stWrEn),
    .wrIndex     (getIndex(req.address)),
    .wrOffset    (stWrOffset),
    .wrData      (stWrData),
    .validateEn  (stValidate),
    .validateTag (getTag(req.address))
  );

  // State register; reset returns to IDLE at once so memory strobes drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state, memory strobes and storage write controls for the current state.
  always_comb begin
    nextState      = state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = memAddrHold;
    mem_write_data = memWdataHold;
    stWrEn         = 1'b0;
    stWrOffset     = getOffset(req.address);
    stWrData       = req.wdata;
    stValidate     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) nextState = LOOKUP;
      end
      LOOKUP: begin
        if (req.we) begin
          // Write-through without allocation: only a resident line is updated.
          stWrEn    = hit;
          nextState = WRITE;
        end else if (hit) begin
          nextState = IDLE;
        end else begin
          nextState = REFILL;
        end
      end
      REFILL: begin
        mem_read    = 1'b1;
        mem_address = blockWordAddress(req.address, refillCnt);
        stWrEn      = 1'b1;
        stWrOffset  = refillCnt;
        stWrData    = mem_read_data;
        if (refillCnt == OFFSET_BITS'(WORDS_PER_BLOCK - 1)) begin
          stValidate = 1'b1;
          nextState  = RESPOND;
        end
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = req.address;
        mem_write_data = req.wdata;
        nextState      = IDLE;
      end
      RESPOND: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request latch, refill beat counter, CPU response, hit/miss counters and bus hold values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req          <= '0;
      refillCnt    <= '0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      memAddrHold  <= '0;
      memWdataHold <= '0;
    end else begin
      cpu_ready    <= 1'b0;
      memAddrHold  <= mem_address;
      memWdataHold <= mem_write_data;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req.we      <= cpu_we;
            req.address <= cpu_address;
            req.wdata   <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (!req.we) begin
            if (hit) begin
              cpu_rdata <= rdData;
              cpu_ready <= 1'b1;
              hit_count <= satInc(hit_count);
            end else begin
              miss_count <= satInc(miss_count);
              refillCnt  <= '0;
            end
          end
        end
        REFILL: begin
          refillCnt <= refillCnt + OFFSET_BITS'(1);
        end
        RESPOND: begin
          cpu_rdata <= rdData;
          cpu_ready <= 1'b1;
        end
        WRITE: begin
          cpu_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
